// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types and constants for the pipeline skid buffer.
//                - pipe_skid_state_e : control state, explicit 2-bit encoding
//                - SkidDepth         : number of storage entries (main + skid)
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

    localparam int SkidDepth = 2;

    // Bit 0 set means the main entry is valid; bit 1 set means the skid
    // entry is valid. 2'b10 is unused and recovers to EMPTY.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b11
    } pipe_skid_state_e;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_skid_buffer_dffr.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_buffer_dffr
//  Description : Reset-value flip-flop cell. Loads d on every rising CLK edge;
//                an asynchronous low RSTN forces q to DRST.
//  Ports       : CLK  - clock
//                RSTN - asynchronous active-low reset
//                d    - next value (load-enable mux lives in the caller)
//                q    - registered value
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_skid_buffer_dffr #(
    parameter int          WIDTH = 8,
    parameter logic [WIDTH-1:0] DRST  = '0
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            q <= DRST;
        end else begin
            q <= d;
        end
    end

endmodule : pipe_skid_buffer_dffr
`default_nettype wire

// File: rtl/pipe_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_buffer
//  Description : Two-entry valid/ready skid buffer. Full throughput, one-cycle
//                forward latency, in_ready and out_valid driven from flops.
//  Ports       : CLK       - clock, rising edge
//                RSTN      - asynchronous active-low reset
//                flush     - synchronous clear of all held words
//                in_valid  - producer word present on in_data
//                in_ready  - buffer can accept a word (registered)
//                in_data   - producer word
//                out_valid - main entry holds a word (registered)
//                out_ready - consumer accepts out_data
//                out_data  - main entry word (registered)
//                count     - occupancy 0..2 (registered)
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_skid_buffer
    import pipe_pkg::*;
#(
    parameter int               Width  = 8,
    parameter logic [Width-1:0] RstVal = '0
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_data,
    output logic [1:0]       count
);

    localparam logic [1:0] c_max_count = 2'(SkidDepth);

    pipe_skid_state_e r_state;
    pipe_skid_state_e w_state_next;

    logic             r_in_ready;
    logic             r_out_valid;
    logic [1:0]       r_count;

    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_in_ready_next;
    logic             w_out_valid_next;
    logic [1:0]       w_count_next;

    logic [Width-1:0] w_main_d;
    logic [Width-1:0] w_skid_d;
    logic [Width-1:0] w_main_q;
    logic [Width-1:0] w_skid_q;

    assign w_in_fire  = in_valid  & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    // ------------------------------------------------------------------
    // State register. Handshake flags and count are registered alongside
    // the state so that no output passes through decode logic.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= w_in_ready_next;
            r_out_valid <= w_out_valid_next;
            r_count     <= w_count_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Flush overrides every transfer; the unused
    // encoding falls through to EMPTY.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = EMPTY;
        if (!flush) begin
            case (r_state)
                EMPTY: w_state_next = w_in_fire ? BUSY : EMPTY;
                BUSY: begin
                    if (w_in_fire && !w_out_fire) begin
                        w_state_next = FULL;
                    end else if (w_out_fire && !w_in_fire) begin
                        w_state_next = EMPTY;
                    end else begin
                        w_state_next = BUSY;
                    end
                end
                FULL:    w_state_next = w_out_fire ? BUSY : FULL;
                default: w_state_next = EMPTY;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output / datapath logic: next values of the registered flags and
    // the D inputs of the two storage cells (hold = feed q back).
    // ------------------------------------------------------------------
    always_comb begin
        w_in_ready_next  = (w_state_next != FULL);
        w_out_valid_next = (w_state_next != EMPTY);
        case (w_state_next)
            BUSY:    w_count_next = 2'd1;
            FULL:    w_count_next = c_max_count;
            default: w_count_next = 2'd0;
        endcase

        w_main_d = w_main_q;
        w_skid_d = w_skid_q;
        if (flush) begin
            w_main_d = RstVal;
            w_skid_d = RstVal;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_main_d = in_data;
                    end
                end
                BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_d = in_data;
                    end else if (w_in_fire) begin
                        w_skid_d = in_data;
                    end else if (w_out_fire) begin
                        w_main_d = RstVal;
                    end
                end
                FULL: begin
                    if (w_out_fire) begin
                        w_main_d = w_skid_q;
                        w_skid_d = RstVal;
                    end
                end
                default: begin
                    w_main_d = RstVal;
                    w_skid_d = RstVal;
                end
            endcase
        end
    end

    pipe_skid_buffer_dffr #(
        .WIDTH (Width),
        .DRST  (RstVal)
    ) u_main (
        .CLK  (CLK),
        .RSTN (RSTN),
        .d    (w_main_d),
        .q    (w_main_q)
    );

    pipe_skid_buffer_dffr #(
        .WIDTH (Width),
        .DRST  (RstVal)
    ) u_skid (
        .CLK  (CLK),
        .RSTN (RSTN),
        .d    (w_skid_d),
        .q    (w_skid_q)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = w_main_q;
    assign count     = r_count;

`ifndef SYNTHESIS
    always @(posedge CLK) begin
        if (RSTN) begin
            assert (!(r_out_valid && $isunknown(w_main_q)))
                else $error("out_data is X while out_valid is high");
            assert (r_count <= c_max_count)
                else $error("count exceeds buffer depth");
        end
    end
`endif

endmodule : pipe_skid_buffer
`default_nettype wire

// File: tb/tb_pipe_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_skid_buffer
//  Description : Directed self-checking bench for pipe_skid_buffer
//                (Width = 8, RstVal = 8'h00).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_skid_buffer;

    logic       CLK;
    logic       RSTN;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] count;

    int total;
    int bad;

    pipe_skid_buffer #(
        .Width  (8),
        .RstVal (8'h00)
    ) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance past the next rising edge; outputs are then settled.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RSTN = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        #12;
        total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 8'h00)  begin bad++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        total++; if (count !== 2'd0)      begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        step();
        RSTN = 1'b1;
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1)  begin bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        total++; if (out_data !== 8'hA5)  begin bad++; $display("FAIL single_data got=%h exp=a5", out_data); end
        total++; if (count !== 2'd1)      begin bad++; $display("FAIL single_count got=%0d exp=1", count); end
        step();
        total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL single_drain_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 8'h00)  begin bad++; $display("FAIL single_drain_data got=%h exp=00", out_data); end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'(i + 1);
            step();
            total++; if (out_valid !== 1'b1)    begin bad++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, out_valid); end
            total++; if (out_data !== 8'(i + 1)) begin bad++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, out_data, 8'(i + 1)); end
            total++; if (in_ready !== 1'b1)     begin bad++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready); end
            total++; if (count !== 2'd1)        begin bad++; $display("FAIL stream_count[%0d] got=%0d exp=1", i, count); end
        end
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_end_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h10;
        step();
        total++; if (count !== 2'd1)     begin bad++; $display("FAIL bp_count1 got=%0d exp=1", count); end
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL bp_in_ready1 got=%b exp=1", in_ready); end
        in_data = 8'h11;
        step();
        total++; if (count !== 2'd2)     begin bad++; $display("FAIL bp_count2 got=%0d exp=2", count); end
        total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL bp_in_ready2 got=%b exp=0", in_ready); end
        total++; if (out_data !== 8'h10) begin bad++; $display("FAIL bp_head got=%h exp=10", out_data); end
        in_data = 8'h12;
        step();
        total++; if (count !== 2'd2)     begin bad++; $display("FAIL bp_hold_count got=%0d exp=2", count); end
        total++; if (out_data !== 8'h10) begin bad++; $display("FAIL bp_hold_data got=%h exp=10", out_data); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got=%b exp=1", out_valid); end
        // 8'h10 leaves on this edge; 8'h12 is still refused.
        out_ready = 1'b1;
        step();
        total++; if (out_data !== 8'h11) begin bad++; $display("FAIL bp_out2 got=%h exp=11", out_data); end
        total++; if (count !== 2'd1)     begin bad++; $display("FAIL bp_out2_count got=%0d exp=1", count); end
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL bp_out2_in_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        total++; if (out_data !== 8'h12) begin bad++; $display("FAIL bp_out3 got=%h exp=12", out_data); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out3_valid got=%b exp=1", out_valid); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b exp=0", out_valid); end
        total++; if (count !== 2'd0)     begin bad++; $display("FAIL bp_drained_count got=%0d exp=0", count); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h20;
        step();
        in_data = 8'h21;
        step();
        total++; if (count !== 2'd2)     begin bad++; $display("FAIL flush_pre_count got=%0d exp=2", count); end
        flush = 1'b1; in_data = 8'h22;
        step();
        flush = 1'b0; in_valid = 1'b0;
        total++; if (count !== 2'd0)     begin bad++; $display("FAIL flush_count got=%0d exp=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL flush_data got=%h exp=00", out_data); end
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
        out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL flush_dropped_data got=%h exp=00", out_data); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h40;
        step();
        in_data = 8'h41;
        step();
        in_valid = 1'b0;
        total++; if (count !== 2'd2)     begin bad++; $display("FAIL arst_pre_count got=%0d exp=2", count); end
        #2;
        RSTN = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL arst_in_ready got=%b exp=1", in_ready); end
        total++; if (count !== 2'd0)     begin bad++; $display("FAIL arst_count got=%0d exp=0", count); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL arst_data got=%h exp=00", out_data); end
        #1;
        RSTN = 1'b1;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_after_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h32;
        step();
        out_ready = 1'b1; in_data = 8'h33;
        total++; if (out_data !== 8'h32) begin bad++; $display("FAIL b2b_head got=%h exp=32", out_data); end
        step();
        in_valid = 1'b0;
        total++; if (out_data !== 8'h33) begin bad++; $display("FAIL b2b_next got=%h exp=33", out_data); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b exp=1", out_valid); end
        total++; if (count !== 2'd1)     begin bad++; $display("FAIL b2b_count got=%0d exp=1", count); end
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b exp=0", out_valid); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pipe_skid_buffer
`default_nettype wire
